// File: rtl/neuron_lut_loader_if.sv
// Configuration stream and lookup port bundle for neuron_lut_loader.
// master drives beats and lookup requests; slave is the loader.
interface neuron_lut_loader_if #(
  parameter int unsigned IN_BITS = 8,
  parameter int unsigned LOAD_W  = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [LOAD_W-1:0] cfg_data;
  logic              cfg_last;

  logic               in_valid;
  logic [IN_BITS-1:0] M0;
  logic               out_valid;
  logic               M1;

  modport master (
    output cfg_valid, cfg_data, cfg_last, in_valid, M0,
    input  cfg_ready, out_valid, M1
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, in_valid, M0,
    output cfg_ready, out_valid, M1
  );
endinterface

// File: rtl/neuron_lut_loader.sv
// Runtime-loadable 2^IN_BITS x 1 truth-table neuron with stream loader and registered lookup.
// Optional macro LUT_CRC_EN appends a CRC-8 (poly 0x07) beat to each image; LOAD_W must then be 8.
module neuron_lut_loader #(
  parameter int unsigned IN_BITS = 8,
  parameter int unsigned LOAD_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  neuron_lut_loader_if.slave  bus,
  output logic                load_done,
  output logic                load_err,
  output logic                table_valid
);
  localparam int unsigned DEPTH  = 2 ** IN_BITS;
  localparam int unsigned NBEATS = DEPTH / LOAD_W;
  localparam int unsigned SEL_W  = $clog2(LOAD_W);
  localparam int unsigned WA_W   = IN_BITS - SEL_W;
`ifdef LUT_CRC_EN
  localparam int unsigned LAST_IDX = NBEATS;
`else
  localparam int unsigned LAST_IDX = NBEATS - 1;
`endif
  localparam int unsigned CNT_W  = $clog2(LAST_IDX + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_ERR} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_ready_q;
  logic               load_done_q, load_done_d;
  logic               load_err_q, load_err_d;
  logic               table_valid_q, table_valid_d;
  logic               out_valid_q, out_valid_d;
  logic               m1_q, m1_d;

  logic               beat_acc;
  logic               wr_en;
  logic [CNT_W-1:0]   idx;
  logic [LOAD_W-1:0]  rd_word;

  logic [LOAD_W-1:0]  mem_q [NBEATS];

`ifdef LUT_CRC_EN
  logic [7:0] crc_q, crc_d;

  // CRC-8, poly 0x07, MSB-first over one beat.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [LOAD_W-1:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc_in;
    for (int i = int'(LOAD_W) - 1; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cfg_ready_q   <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      table_valid_q <= 1'b0;
      out_valid_q   <= 1'b0;
      m1_q          <= 1'b0;
`ifdef LUT_CRC_EN
      crc_q         <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cfg_ready_q   <= 1'b1;
      load_done_q   <= load_done_d;
      load_err_q    <= load_err_d;
      table_valid_q <= table_valid_d;
      out_valid_q   <= out_valid_d;
      m1_q          <= m1_d;
`ifdef LUT_CRC_EN
      crc_q         <= crc_d;
`endif
    end
  end

  // Table storage is never reset; table_valid_q gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx[WA_W-1:0]] <= bus.cfg_data;
    end
  end

  // Loader FSM: a beat outside LOAD always starts a fresh image at index 0.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load_done_d   = 1'b0;
    load_err_d    = load_err_q;
    table_valid_d = table_valid_q;
    wr_en         = 1'b0;
    beat_acc      = bus.cfg_valid && cfg_ready_q;
    idx           = (state_q == S_LOAD) ? cnt_q : '0;
`ifdef LUT_CRC_EN
    crc_d         = crc_q;
`endif

    if (beat_acc) begin
      if (state_q != S_LOAD) begin
        table_valid_d = 1'b0;
        load_err_d    = 1'b0;
      end
      state_d = S_LOAD;
      cnt_d   = idx + CNT_W'(1);
`ifdef LUT_CRC_EN
      if (idx == CNT_W'(LAST_IDX)) begin
        cnt_d = '0;
        if (bus.cfg_last && (bus.cfg_data == LOAD_W'(crc_q))) begin
          state_d       = S_READY;
          table_valid_d = 1'b1;
          load_done_d   = 1'b1;
        end else begin
          state_d    = S_ERR;
          load_err_d = 1'b1;
        end
      end else begin
        wr_en = 1'b1;
        crc_d = crc8_step((idx == '0) ? 8'h00 : crc_q, bus.cfg_data);
        if (bus.cfg_last) begin
          cnt_d      = '0;
          state_d    = S_ERR;
          load_err_d = 1'b1;
        end
      end
`else
      wr_en = 1'b1;
      if (idx == CNT_W'(LAST_IDX)) begin
        cnt_d = '0;
        if (bus.cfg_last) begin
          state_d       = S_READY;
          table_valid_d = 1'b1;
          load_done_d   = 1'b1;
        end else begin
          state_d    = S_ERR;
          load_err_d = 1'b1;
        end
      end else if (bus.cfg_last) begin
        cnt_d      = '0;
        state_d    = S_ERR;
        load_err_d = 1'b1;
      end
`endif
    end
  end

  // Lookup reads the pre-edge table, so a request alongside a first beat sees old data.
  always_comb begin
    rd_word     = mem_q[bus.M0[IN_BITS-1:SEL_W]];
    out_valid_d = bus.in_valid && table_valid_q;
    m1_d        = bus.in_valid && table_valid_q && rd_word[bus.M0[SEL_W-1:0]];
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.M1        = m1_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign table_valid   = table_valid_q;

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Directed bench for neuron_lut_loader: lookup results checked against a scoreboard queue.
module tb_neuron_lut_loader;
  localparam int unsigned IN_BITS = 8;
  localparam int unsigned LOAD_W  = 8;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned NBEATS  = 32;

  typedef struct packed {
    logic ov;
    logic m1;
    logic chk_m1;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic load_done, load_err, table_valid;

  neuron_lut_loader_if #(.IN_BITS(IN_BITS), .LOAD_W(LOAD_W)) bus ();

  neuron_lut_loader #(.IN_BITS(IN_BITS), .LOAD_W(LOAD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .load_done   (load_done),
    .load_err    (load_err),
    .table_valid (table_valid)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       exp_q[$];
  bit         ref_mem [DEPTH];
  bit         exp_tv;
  logic [7:0] img [NBEATS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: queue the expected lookup result, advance, then compare it.
  task automatic tick();
    exp_t e;
    e.ov     = bus.in_valid && exp_tv;
    e.m1     = (bus.in_valid && exp_tv) ? ref_mem[bus.M0] : 1'b0;
    e.chk_m1 = e.ov || !exp_tv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, e.ov});
    if (e.chk_m1) check("M1", {31'd0, bus.M1}, {31'd0, e.m1});
  endtask

  task automatic send_beat(input int k, input logic [7:0] d, input logic last, input bit wr);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = d;
    bus.cfg_last  = last;
    tick();
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
    if (wr) begin
      for (int j = 0; j < 8; j++) ref_mem[k*8 + j] = d[j];
    end
    if (k == 0) exp_tv = 1'b0;
  endtask

`ifdef LUT_CRC_EN
  function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction
`endif

  // Sends img[] as a complete image; crc_bad corrupts the CRC beat when CRC is enabled.
  task automatic send_image(input bit crc_bad);
`ifdef LUT_CRC_EN
    logic [7:0] crc;
    crc = 8'h00;
`endif
    for (int k = 0; k < int'(NBEATS); k++) begin
      bit fin;
      fin = 1'b0;
`ifndef LUT_CRC_EN
      fin = (k == int'(NBEATS) - 1);
`else
      crc = crc8(crc, img[k]);
`endif
      send_beat(k, img[k], fin, 1'b1);
      check("load_done", {31'd0, load_done},   {31'd0, fin && !crc_bad});
      check("load_err",  {31'd0, load_err},    {31'd0, fin && crc_bad});
      check("table_vld", {31'd0, table_valid}, {31'd0, fin && !crc_bad});
    end
`ifdef LUT_CRC_EN
    send_beat(NBEATS, crc ^ (crc_bad ? 8'h01 : 8'h00), 1'b1, 1'b0);
    check("crc_done",  {31'd0, load_done},   {31'd0, !crc_bad});
    check("crc_err",   {31'd0, load_err},    {31'd0, crc_bad});
    check("crc_tvld",  {31'd0, table_valid}, {31'd0, !crc_bad});
`endif
    exp_tv = !crc_bad;
    tick();
    check("done_pulse", {31'd0, load_done}, 32'd0);
  endtask

  initial begin
    int ones;
    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.cfg_last  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.M0        = '0;
    exp_tv        = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) ref_mem[k] = 1'b0;

    // Reset values and a dropped lookup after release.
    repeat (3) tick();
    check("rst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd0);
    check("rst_tvld",      {31'd0, table_valid},   32'd0);
    check("rst_err",       {31'd0, load_err},      32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.M0       = 8'h44;
    tick();
    check("cfg_ready",  {31'd0, bus.cfg_ready}, 32'd1);
    check("idle_tvld",  {31'd0, table_valid},   32'd0);
    check("idle_done",  {31'd0, load_done},     32'd0);
    check("idle_ov",    {31'd0, bus.out_valid}, 32'd0);
    check("idle_m1",    {31'd0, bus.M1},        32'd0);
    bus.in_valid = 1'b0;

    // Single-bit image: only entry 0x44 set.
    for (int k = 0; k < int'(NBEATS); k++) img[k] = 8'h00;
    img[8] = 8'h10;
    send_image(1'b0);
    bus.in_valid = 1'b1;
    bus.M0 = 8'h44; tick();
    check("m1_44", {31'd0, bus.M1}, 32'd1);
    bus.M0 = 8'h45; tick();
    check("m1_45", {31'd0, bus.M1}, 32'd0);
    bus.in_valid = 1'b0;

    // All-ones image, full-throughput sweep.
    for (int k = 0; k < int'(NBEATS); k++) img[k] = 8'hFF;
    send_image(1'b0);
    ones = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.M0 = 8'(i);
      tick();
      if (bus.out_valid && bus.M1) ones++;
    end
    check("b2b_ones", 32'(ones), 32'd256);

    // Lookup alongside a first beat sees old data; the next one is dropped.
    bus.M0 = 8'h03;
    send_beat(0, 8'h00, 1'b0, 1'b1);
    check("old_data", {31'd0, bus.M1}, 32'd1);
    check("start_tvld", {31'd0, table_valid}, 32'd0);
    tick();
    check("drop_ov", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b0;

    // Early last on beat 10.
    for (int k = 1; k <= 10; k++) send_beat(k, 8'h00, k == 10, 1'b1);
    check("early_err",  {31'd0, load_err},    32'd1);
    check("early_tvld", {31'd0, table_valid}, 32'd0);
    check("early_done", {31'd0, load_done},   32'd0);
    for (int k = 0; k < int'(NBEATS); k++) img[k] = 8'h00;
    img[8] = 8'h10;
    send_image(1'b0);
    bus.in_valid = 1'b1;
    bus.M0 = 8'h44; tick();
    check("recov_m1", {31'd0, bus.M1}, 32'd1);
    bus.in_valid = 1'b0;

    // Missing last on the final beat.
    for (int k = 0; k < int'(NBEATS); k++) send_beat(k, 8'hA5, 1'b0, 1'b1);
`ifdef LUT_CRC_EN
    send_beat(NBEATS, 8'h00, 1'b0, 1'b0);
`endif
    check("miss_err",  {31'd0, load_err},    32'd1);
    check("miss_tvld", {31'd0, table_valid}, 32'd0);

    // Reset after beat 15 discards the partial image.
    for (int k = 0; k <= 15; k++) send_beat(k, 8'hFF, 1'b0, 1'b1);
    rst = 1'b1; tick();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.M0 = 8'h05; tick();
    bus.M0 = 8'h44; tick();
    check("rst_mid_ov",   {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid_err",  {31'd0, load_err},      32'd0);
    check("rst_mid_tvld", {31'd0, table_valid},   32'd0);
    bus.in_valid = 1'b0;
    send_image(1'b0);
    bus.in_valid = 1'b1;
    bus.M0 = 8'h44; tick();
    check("post_rst_m1", {31'd0, bus.M1}, 32'd1);
    bus.M0 = 8'h05; tick();
    check("post_rst_m1b", {31'd0, bus.M1}, 32'd0);
    bus.in_valid = 1'b0;

`ifdef LUT_CRC_EN
    // Corrupted CRC then a clean resend.
    send_image(1'b1);
    bus.in_valid = 1'b1;
    bus.M0 = 8'h44; tick();
    check("crc_bad_ov", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b0;
    send_image(1'b0);
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
